// File: rtl/ct_spsram_512x96_arb.sv
// Two-requester round-robin arbiter and sequencer for a 512x96 single-port SRAM.
// Define CT_SPSRAM_512X96_INIT_EN to zero-fill the array after reset before traffic is accepted.
module ct_spsram_512x96_arb #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH      = 512
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req0_vld,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [DATA_WIDTH-1:0] req0_wmask,
  output logic                  req0_rdy,
  output logic                  rsp0_vld,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_vld,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [DATA_WIDTH-1:0] req1_wmask,
  output logic                  req1_rdy,
  output logic                  rsp1_vld,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q,
  output logic                  init_done
);

  localparam logic [DATA_WIDTH-1:0] ONES_C  = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ZEROS_C = {DATA_WIDTH{1'b0}};

  generate
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
      $error("DEPTH must equal 2**ADDR_WIDTH");
    end
  endgenerate

  logic                  run_s;
  logic                  init_active_s;
  logic [ADDR_WIDTH-1:0] init_cnt_s;
  logic                  grant0_s;
  logic                  grant1_s;
  logic                  sel_wr_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [DATA_WIDTH-1:0] sel_wmask_s;
  logic                  rr_ptr_r;
  logic                  rsp0_vld_r;
  logic                  rsp1_vld_r;

`ifdef CT_SPSRAM_512X96_INIT_EN
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] INIT_LAST_C = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] init_cnt_r;
  logic                  init_done_r;

  // Init sweep FSM: one zero-write per cycle, then hand the port to the requesters
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= {ADDR_WIDTH{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (init_cnt_r == INIT_LAST_C) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end else begin
            init_cnt_r  <= init_cnt_r + ADDR_WIDTH'(1'b1);
          end
        end
        ST_RUN: begin
          state_r     <= ST_RUN;
          init_done_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_INIT;
          init_cnt_r  <= {ADDR_WIDTH{1'b0}};
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign run_s         = (state_r == ST_RUN);
  assign init_active_s = (state_r == ST_INIT);
  assign init_cnt_s    = init_cnt_r;
  assign init_done     = init_done_r;
`else
  assign run_s         = 1'b1;
  assign init_active_s = 1'b0;
  assign init_cnt_s    = {ADDR_WIDTH{1'b0}};
  assign init_done     = 1'b1;
`endif

  // Grant selection: a lone requester wins, contention goes to rr_ptr_r
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (run_s) begin
      if (req0_vld && req1_vld) begin
        if (rr_ptr_r) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b1;
        end
      end else if (req0_vld) begin
        grant0_s = 1'b1;
      end else if (req1_vld) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Request field mux driven by the winning requester
  always_comb begin
    sel_wr_s    = req0_wr;
    sel_addr_s  = req0_addr;
    sel_wdata_s = req0_wdata;
    sel_wmask_s = req0_wmask;
    if (grant1_s) begin
      sel_wr_s    = req1_wr;
      sel_addr_s  = req1_addr;
      sel_wdata_s = req1_wdata;
      sel_wmask_s = req1_wmask;
    end else begin
      sel_wr_s    = req0_wr;
      sel_addr_s  = req0_addr;
      sel_wdata_s = req0_wdata;
      sel_wmask_s = req0_wmask;
    end
  end

  // SRAM port translation to active-low CEN/GWEN/WEN; idle drives a quiet bus
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = ONES_C;
    sram_a    = {ADDR_WIDTH{1'b0}};
    sram_d    = ZEROS_C;
    if (init_active_s) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ZEROS_C;
      sram_a    = init_cnt_s;
      sram_d    = ZEROS_C;
    end else if (grant0_s || grant1_s) begin
      sram_cen = 1'b0;
      sram_a   = sel_addr_s;
      if (sel_wr_s) begin
        sram_gwen = 1'b0;
        sram_d    = sel_wdata_s;
        sram_wen  = ~sel_wmask_s;
      end else begin
        sram_gwen = 1'b1;
        sram_d    = ZEROS_C;
        sram_wen  = ONES_C;
      end
    end else begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
    end
  end

  // Round-robin pointer and one-cycle read response flags
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rr_ptr_r   <= 1'b0;
      rsp0_vld_r <= 1'b0;
      rsp1_vld_r <= 1'b0;
    end else begin
      if (grant0_s) begin
        rr_ptr_r <= 1'b1;
      end else if (grant1_s) begin
        rr_ptr_r <= 1'b0;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      rsp0_vld_r <= grant0_s & ~req0_wr;
      rsp1_vld_r <= grant1_s & ~req1_wr;
    end
  end

  assign req0_rdy   = grant0_s;
  assign req1_rdy   = grant1_s;
  assign rsp0_vld   = rsp0_vld_r;
  assign rsp1_vld   = rsp1_vld_r;
  // Q already reflects the read launched last cycle, so it is passed straight through
  assign rsp0_rdata = sram_q;
  assign rsp1_rdata = sram_q;

endmodule

// File: tb/tb_ct_spsram_512x96_arb.sv
// Randomized bench for ct_spsram_512x96_arb with a behavioural SRAM and shadow-memory reference model.
module tb_ct_spsram_512x96_arb;

  localparam logic [95:0] ONES_C = {96{1'b1}};

  logic        clk;
  logic        cpurst_b;
  logic        req0_vld, req0_wr, req0_rdy, rsp0_vld;
  logic [8:0]  req0_addr;
  logic [95:0] req0_wdata, req0_wmask, rsp0_rdata;
  logic        req1_vld, req1_wr, req1_rdy, rsp1_vld;
  logic [8:0]  req1_addr;
  logic [95:0] req1_wdata, req1_wmask, rsp1_rdata;
  logic [8:0]  sram_a;
  logic        sram_cen, sram_gwen, init_done;
  logic [95:0] sram_d, sram_wen, sram_q;

  ct_spsram_512x96_arb dut (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b),
    .req0_vld(req0_vld), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wmask(req0_wmask), .req0_rdy(req0_rdy),
    .rsp0_vld(rsp0_vld), .rsp0_rdata(rsp0_rdata),
    .req1_vld(req1_vld), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wmask(req1_wmask), .req1_rdy(req1_rdy),
    .rsp1_vld(rsp1_vld), .rsp1_rdata(rsp1_rdata),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_d(sram_d), .sram_wen(sram_wen), .sram_q(sram_q), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM: per-bit active-low write enable, registered Q
  logic [95:0] mem [0:511];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Next request per requester, held by the bench until accepted
  logic        nv [2];
  logic        nw [2];
  logic [8:0]  na [2];
  logic [95:0] nd [2];
  logic [95:0] nm [2];

  // Reference model: array contents, which bits are known, fairness memory, expected responses
  logic [95:0] shadow [0:511];
  logic [95:0] known  [0:511];
  int          last_gnt;
  logic        erv [2];
  logic [95:0] erd [2];
  logic [95:0] erk [2];
  int          gnt;

  task automatic apply_inputs(input logic en);
    req0_vld = nv[0] & en; req0_wr = nw[0]; req0_addr = na[0]; req0_wdata = nd[0]; req0_wmask = nm[0];
    req1_vld = nv[1] & en; req1_wr = nw[1]; req1_addr = na[1]; req1_wdata = nd[1]; req1_wmask = nm[1];
  endtask

  task automatic set_req(input int r, input logic v, input logic w, input logic [8:0] a,
                         input logic [95:0] d, input logic [95:0] m);
    nv[r] = v; nw[r] = w; na[r] = a; nd[r] = d; nm[r] = m;
  endtask

  task automatic run_cycle();
    int g;
    @(negedge clk);
    apply_inputs(1'b1);
    #1;
    check_eq("init_done", init_done, 1'b1);
    check_eq("rsp0_vld", rsp0_vld, erv[0]);
    check_eq("rsp1_vld", rsp1_vld, erv[1]);
    if (erv[0] && erk[0] != '0) check_eq("rsp0_data", rsp0_rdata & erk[0], erd[0] & erk[0]);
    if (erv[1] && erk[1] != '0) check_eq("rsp1_data", rsp1_rdata & erk[1], erd[1] & erk[1]);
    // Whoever was not served most recently wins a tie
    if (nv[0] && nv[1]) g = (last_gnt == 0) ? 1 : 0;
    else if (nv[0])     g = 0;
    else if (nv[1])     g = 1;
    else                g = -1;
    check_eq("rdy0", req0_rdy, (g == 0));
    check_eq("rdy1", req1_rdy, (g == 1));
    erv[0] = 1'b0;
    erv[1] = 1'b0;
    if (g < 0) begin
      check_eq("idle_cen", sram_cen, 1'b1);
      check_eq("idle_gwen", sram_gwen, 1'b1);
      check_eq("idle_wen", sram_wen, ONES_C);
      check_eq("idle_a", sram_a, 9'd0);
      check_eq("idle_d", sram_d, 96'd0);
    end else begin
      check_eq("cen", sram_cen, 1'b0);
      check_eq("addr", sram_a, na[g]);
      check_eq("gwen", sram_gwen, !nw[g]);
      last_gnt = g;
      if (nw[g]) begin
        check_eq("wr_d", sram_d, nd[g]);
        check_eq("wr_wen", sram_wen, ~nm[g]);
        shadow[na[g]] = (shadow[na[g]] & ~nm[g]) | (nd[g] & nm[g]);
        known[na[g]]  = known[na[g]] | nm[g];
      end else begin
        check_eq("rd_wen", sram_wen, ONES_C);
        erv[g] = 1'b1;
        erd[g] = shadow[na[g]];
        erk[g] = known[na[g]];
      end
    end
    gnt = g;
  endtask

  task automatic do_reset();
    cpurst_b = 1'b0;
    apply_inputs(1'b0);
    last_gnt = 1;
    erv[0] = 1'b0;
    erv[1] = 1'b0;
    gnt = -1;
    #1;
    check_eq("rst_rsp0", rsp0_vld, 1'b0);
    check_eq("rst_rsp1", rsp1_vld, 1'b0);
    repeat (2) @(negedge clk);
`ifdef CT_SPSRAM_512X96_INIT_EN
    apply_inputs(1'b1);
    cpurst_b = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check_eq("init_a", sram_a, i[8:0]);
      check_eq("init_done_lo", init_done, 1'b0);
      check_eq("init_rdy", {req1_rdy, req0_rdy}, 2'b00);
      check_eq("init_wr", {sram_cen, sram_gwen}, 2'b00);
      check_eq("init_wen", sram_wen, 96'd0);
    end
    for (int i = 0; i < 512; i++) begin
      shadow[i] = '0;
      known[i]  = ONES_C;
    end
`else
    check_eq("rst_init_done", init_done, 1'b1);
    cpurst_b = 1'b1;
`endif
  endtask

  function automatic logic [8:0] pick_addr(input int k);
    if (k < 6)       return 9'(k);
    else if (k == 6) return 9'h1A5;
    else             return 9'h1FF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]    = {3{32'hDEAD_0000 ^ i}};
      shadow[i] = '0;
      known[i]  = '0;
    end
    for (int r = 0; r < 2; r++) set_req(r, 1'b0, 1'b0, 9'd0, 96'd0, 96'd0);
    erk[0] = '0;
    erk[1] = '0;
    erd[0] = '0;
    erd[1] = '0;
    do_reset();

    // Single write then read on requester 0
    set_req(0, 1'b1, 1'b1, 9'h1A5, 96'h0123_4567_89AB_CDEF_0011_2233, ONES_C);
    run_cycle();
    set_req(0, 1'b1, 1'b0, 9'h1A5, 96'd0, 96'd0);
    run_cycle();
    nv[0] = 1'b0;
    run_cycle();
    check_eq("swr_data", rsp0_rdata, 96'h0123_4567_89AB_CDEF_0011_2233);

    // Partial mask on address 5
    set_req(1, 1'b1, 1'b1, 9'd5, ONES_C, ONES_C);
    run_cycle();
    set_req(1, 1'b1, 1'b1, 9'd5, 96'd0, 96'hFF);
    run_cycle();
    set_req(1, 1'b1, 1'b0, 9'd5, 96'd0, 96'd0);
    run_cycle();
    nv[1] = 1'b0;
    run_cycle();
    check_eq("pm_data", rsp1_rdata, {{88{1'b1}}, 8'h00});

    // Idle stretch; fairness state must survive it
    repeat (10) run_cycle();

    // Continuous contention straight after reset
    do_reset();
    set_req(0, 1'b1, 1'b0, 9'h1A5, 96'd0, 96'd0);
    set_req(1, 1'b1, 1'b0, 9'd5, 96'd0, 96'd0);
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      check_eq("cont_gnt", gnt, i % 2);
    end
    nv[0] = 1'b0;
    nv[1] = 1'b0;
    run_cycle();

    // Reset while a read response is due; pointer must return to favour req0
    set_req(0, 1'b1, 1'b0, 9'h1A5, 96'd0, 96'd0);
    run_cycle();
    nv[0] = 1'b0;
    @(posedge clk);
    #2;
    check_eq("mid_rsp_pre", rsp0_vld, 1'b1);
    cpurst_b = 1'b0;
    #1;
    check_eq("mid_rsp_drop", rsp0_vld, 1'b0);
    set_req(0, 1'b1, 1'b0, 9'h1FF, 96'd0, 96'd0);
    set_req(1, 1'b1, 1'b0, 9'h1FF, 96'd0, 96'd0);
    do_reset();
    run_cycle();
    check_eq("rst_rr", gnt, 0);
    nv[0] = 1'b0;
    run_cycle();
    nv[1] = 1'b0;
    run_cycle();
`ifdef CT_SPSRAM_512X96_INIT_EN
    check_eq("init_rd511", rsp1_rdata, 96'd0);
`endif

    // Randomized traffic over a small address pool
    gnt = -1;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!nv[r] || gnt == r) begin
          nv[r] = ($urandom_range(0, 3) != 0);
          nw[r] = 1'($urandom_range(0, 1));
          na[r] = pick_addr($urandom_range(0, 7));
          nd[r] = {$urandom, $urandom, $urandom};
          nm[r] = ($urandom_range(0, 1) != 0) ? ONES_C : {$urandom, $urandom, $urandom};
        end
      end
      run_cycle();
    end
    nv[0] = 1'b0;
    nv[1] = 1'b0;
    repeat (2) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ct_spsram_512x96_arb.md
Name: ct_spsram_512x96_arb

Overview:
- Two-requester arbiter and sequencer in front of one 512x96 single-port SRAM instance.
- Converts per-requester valid/ready read and write requests into the SRAM's active-low CEN/GWEN/WEN protocol.
- Returns read data with fixed latency and shares the single port by round-robin.
- Sits between L2/L1 array users (e.g. a refill path and a lookup path) and the SRAM wrapper.

Parameters:
- ADDR_WIDTH, 9, SRAM address width.
- DATA_WIDTH, 96, data and mask width.
- DEPTH, 512, number of entries; used by the init sweep; must equal 2**ADDR_WIDTH.

Ports:
- forever_cpuclk  in  1  block clock, also the SRAM CLK.
- cpurst_b  in  1  asynchronous active-low reset.
- req0_vld  in  1  requester 0 request valid.
- req0_wr  in  1  1=write, 0=read.
- req0_addr  in  ADDR_WIDTH  entry index.
- req0_wdata  in  DATA_WIDTH  write data.
- req0_wmask  in  DATA_WIDTH  per-bit write enable, 1=write bit.
- req0_rdy  out  1  request accepted this cycle.
- rsp0_vld  out  1  read data valid.
- rsp0_rdata  out  DATA_WIDTH  read data.
- req1_vld, req1_wr, req1_addr, req1_wdata, req1_wmask, req1_rdy, rsp1_vld, rsp1_rdata: same as requester 0.
- sram_a  out  ADDR_WIDTH  SRAM A.
- sram_cen  out  1  SRAM CEN, active-low.
- sram_gwen  out  1  SRAM GWEN, 0=write.
- sram_d  out  DATA_WIDTH  SRAM D.
- sram_wen  out  DATA_WIDTH  SRAM WEN, per-bit active-low.
- sram_q  in  DATA_WIDTH  SRAM Q.
- init_done  out  1  array ready for traffic.

Behaviour:
- Clock and reset: one clock, forever_cpuclk; reset cpurst_b is asynchronous, active-low. All state clears immediately on cpurst_b=0.
- FSM states: INIT, RUN. Reset enters INIT when the optional feature is compiled in, otherwise RUN.
- Reset values: rsp0_vld=0, rsp1_vld=0, round-robin pointer rr_ptr=0 (favours req0), init counter=0. init_done=0 in the INIT build, 1 otherwise.
- SRAM port outputs are combinational from the grant. They carry no reset value of their own.
- Idle SRAM port (no grant): sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- Grants in RUN:
  - At most one grant per cycle.
  - Only one vld high: that requester is granted.
  - Both high: requester rr_ptr is granted.
  - reqN_rdy = grantN, combinational. Handshake completes when vld & rdy.
  - Requester holds all request fields stable while vld=1 and rdy=0. vld must not drop before acceptance.
- rr_ptr update: on any grant, rr_ptr <= ~granted_index. Unchanged when no grant. Strict alternation under continuous contention, no starvation.
- Granted write: sram_cen=0, sram_gwen=0, sram_a=addr, sram_d=wdata, sram_wen=~wmask.
  - wmask=0 still performs the access but changes no bit.
  - No response is generated for a write.
- Granted read: sram_cen=0, sram_gwen=1, sram_wen=all 1, sram_a=addr.
- Read latency:
  - Read accepted in cycle T: rspN_vld=1 in cycle T+1 only (registered flag). rspN_rdata=sram_q in T+1 (direct path).
  - rspN_rdata is don't-care when rspN_vld=0.
  - No response backpressure; the requester must accept.
- Back-to-back: a new grant in T+1 is legal while the T read response is returned. Only one rsp_vld can be high per cycle.
- Read-after-write to the same address in consecutive grants returns the new data, because the SRAM write completes at the edge ending T. No bypass is needed.
- Reset asserted mid-operation: a pending response is dropped (rsp_vld cleared). A write in flight at the reset edge is undefined in the array.

Optional Feature:
- Macro: CT_SPSRAM_512X96_INIT_EN.
- Defined:
  - Reset enters INIT. The FSM writes all-zero data with full mask (sram_wen=0, sram_gwen=0, sram_cen=0) to addresses 0..DEPTH-1, one per cycle, using a 9-bit counter.
  - During INIT: req0_rdy=req1_rdy=0, init_done=0.
  - After writing address DEPTH-1, the FSM moves to RUN on the next edge and init_done=1 from that cycle on.
  - Sweep length is exactly 512 cycles after reset release.
  - Requests presented during INIT wait.
- Undefined: no INIT state, no counter, init_done tied to 1, array contents after reset unspecified.

Test Plan:
- Single write then read: req0 writes addr 0x1A5, wdata=96'h0123_4567_89AB_CDEF_0011_2233, wmask all 1 -> next cycle req0 reads 0x1A5 -> rsp0_vld=1 exactly one cycle after accept, rsp0_rdata=that value, rsp1_vld=0.
- Contention: req0 and req1 both read continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; rsp0/rsp1 alternate one cycle later; never both rdy high.
- Partial mask: write addr 5 with all-1 data, then write addr 5 with data 0 and wmask=96'hFF -> read returns 96'hFFFF...FF00; sram_wen during the second write = ~96'hFF.
- Idle: no vld for 10 cycles -> sram_cen=1, sram_gwen=1, sram_wen all 1, rr_ptr unchanged.
- Reset mid-read: accept a read, assert cpurst_b=0 before the next edge -> rsp_vld=0 immediately, rr_ptr=0 after release.
- INIT (macro on): after reset release, requests held -> rdy=0 and init_done=0 for 512 cycles, sram_a sweeps 0..511; a read of addr 511 afterwards returns 0.
